tbox_game_ctrl: RTL and testbench

- Turn sequencer and move arbiter in front of the 3x3 board (TBox: valid[8:0], symbol[8:0], game_state[1:0]).
- Accepts move requests from two players, grants only the player whose turn it is, and rejects illegal moves.
- Drives the board's set/row/col/reset strobes, waits for the board's registered result, and reports the outcome.
- Player 1 always plays symbol 1, which is the board's first symbol after reset. Player 2 plays symbol 0.

---
 rtl/tbox_game_ctrl_if.sv | 37 +++
 rtl/tbox_game_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_tbox_game_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tbox_game_ctrl_if.sv
// rtl/tbox_game_ctrl_if.sv - player request/response and board strobe bundle for tbox_game_ctrl
interface tbox_game_ctrl_if;
    logic       new_game;
    logic       p1_req;
    logic [1:0] p1_row;
    logic [1:0] p1_col;
    logic       p2_req;
    logic [1:0] p2_row;
    logic [1:0] p2_col;
    logic       p1_ack;
    logic       p1_nak;
    logic       p2_ack;
    logic       p2_nak;
    logic [8:0] brd_valid;
    logic [1:0] brd_state;
    logic       brd_set;
    logic       brd_reset;
    logic [1:0] brd_row;
    logic [1:0] brd_col;
    logic       turn;
    logic       busy;
    logic       game_over;
    logic [1:0] winner;
    logic [3:0] move_count;

    modport master (
        output new_game, p1_req, p1_row, p1_col, p2_req, p2_row, p2_col, brd_valid, brd_state,
        input  p1_ack, p1_nak, p2_ack, p2_nak, brd_set, brd_reset, brd_row, brd_col,
               turn, busy, game_over, winner, move_count
    );

    modport slave (
        input  new_game, p1_req, p1_row, p1_col, p2_req, p2_row, p2_col, brd_valid, brd_state,
        output p1_ack, p1_nak, p2_ack, p2_nak, brd_set, brd_reset, brd_row, brd_col,
               turn, busy, game_over, winner, move_count
    );
endinterface

// File: rtl/tbox_game_ctrl.sv
// rtl/tbox_game_ctrl.sv - turn sequencer and move arbiter in front of the TBox board
// Optional move forfeit timer enabled by defining TBOX_CTRL_MOVE_TIMEOUT_EN.
module tbox_game_ctrl #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    tbox_game_ctrl_if.slave   bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {S_CLEAR, S_WAIT_MOVE, S_ISSUE, S_SETTLE, S_OVER} state_t;

    state_t        state_q, state_d;
    logic          clr_cnt_q, clr_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic          turn_q, turn_d;
    logic [3:0]    move_count_q, move_count_d;
    logic [1:0]    winner_q, winner_d;
    logic          game_over_q, game_over_d;
    logic [1:0]    brd_row_q, brd_row_d;
    logic [1:0]    brd_col_q, brd_col_d;
    logic          p1_ack_q, p1_ack_d, p1_nak_q, p1_nak_d;
    logic          p2_ack_q, p2_ack_d, p2_nak_q, p2_nak_d;
    logic          p1_seen_q, p1_seen_d, p2_seen_q, p2_seen_d;
`ifdef TBOX_CTRL_MOVE_TIMEOUT_EN
    logic [15:0]   to_cnt_q, to_cnt_d;
`endif

    logic          p1_new, p2_new, on_new, off_new, legal;
    logic [1:0]    on_row, on_col;
    logic [3:0]    cell_idx;
    logic [15:0]   valid_ext;

    // A request is only considered once per raise; seen clears when req drops.
    assign p1_new    = bus.p1_req && !p1_seen_q;
    assign p2_new    = bus.p2_req && !p2_seen_q;
    assign on_new    = turn_q ? p2_new : p1_new;
    assign off_new   = turn_q ? p1_new : p2_new;
    assign on_row    = turn_q ? bus.p2_row : bus.p1_row;
    assign on_col    = turn_q ? bus.p2_col : bus.p1_col;
    assign cell_idx  = ({2'b00, on_row} * 4'd3) + {2'b00, on_col} - 4'd4;
    assign valid_ext = {7'd0, bus.brd_valid};
    assign legal     = (on_row != 2'd0) && (on_col != 2'd0) && !valid_ext[cell_idx];

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = 1'b0;
        settle_cnt_d = '0;
        turn_d       = turn_q;
        move_count_d = move_count_q;
        winner_d     = winner_q;
        game_over_d  = game_over_q;
        brd_row_d    = brd_row_q;
        brd_col_d    = brd_col_q;
        p1_ack_d     = 1'b0;
        p1_nak_d     = 1'b0;
        p2_ack_d     = 1'b0;
        p2_nak_d     = 1'b0;
        p1_seen_d    = p1_seen_q && bus.p1_req;
        p2_seen_d    = p2_seen_q && bus.p2_req;

        case (state_q)
            S_CLEAR: begin
                turn_d       = 1'b0;
                move_count_d = 4'd0;
                winner_d     = 2'b00;
                game_over_d  = 1'b0;
                if (clr_cnt_q) begin
                    state_d = S_WAIT_MOVE;
                end else begin
                    clr_cnt_d = 1'b1;
                end
            end
            S_WAIT_MOVE: begin
                if (off_new) begin
                    if (turn_q) begin
                        p1_nak_d  = 1'b1;
                        p1_seen_d = 1'b1;
                    end else begin
                        p2_nak_d  = 1'b1;
                        p2_seen_d = 1'b1;
                    end
                end
                if (on_new) begin
                    if (turn_q) begin
                        p2_seen_d = 1'b1;
                        p2_ack_d  = legal;
                        p2_nak_d  = !legal;
                    end else begin
                        p1_seen_d = 1'b1;
                        p1_ack_d  = legal;
                        p1_nak_d  = !legal;
                    end
                    if (legal) begin
                        brd_row_d    = on_row;
                        brd_col_d    = on_col;
                        move_count_d = move_count_q + 4'd1;
                        state_d      = S_ISSUE;
                    end
                end
`ifdef TBOX_CTRL_MOVE_TIMEOUT_EN
                // The player on turn forfeits; the opponent is credited.
                if (state_d == S_WAIT_MOVE && to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    winner_d    = turn_q ? 2'b01 : 2'b10;
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end
`endif
            end
            S_ISSUE: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    if (bus.brd_state != 2'b00) begin
                        winner_d    = bus.brd_state;
                        game_over_d = 1'b1;
                        state_d     = S_OVER;
                    end else if (move_count_q == 4'd9) begin
                        winner_d    = 2'b11;
                        game_over_d = 1'b1;
                        state_d     = S_OVER;
                    end else begin
                        turn_d  = !turn_q;
                        state_d = S_WAIT_MOVE;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_OVER: begin
                if (p1_new) begin
                    p1_nak_d  = 1'b1;
                    p1_seen_d = 1'b1;
                end
                if (p2_new) begin
                    p2_nak_d  = 1'b1;
                    p2_seen_d = 1'b1;
                end
            end
            default: state_d = S_CLEAR;
        endcase

`ifdef TBOX_CTRL_MOVE_TIMEOUT_EN
        to_cnt_d = (state_q == S_WAIT_MOVE) ? to_cnt_q + 16'd1 : 16'd0;
`endif

        // new_game drops any in-flight move and any response pending this cycle.
        if (bus.new_game && state_q != S_CLEAR) begin
            state_d      = S_CLEAR;
            settle_cnt_d = '0;
            turn_d       = 1'b0;
            move_count_d = 4'd0;
            winner_d     = 2'b00;
            game_over_d  = 1'b0;
            p1_ack_d     = 1'b0;
            p1_nak_d     = 1'b0;
            p2_ack_d     = 1'b0;
            p2_nak_d     = 1'b0;
            p1_seen_d    = p1_seen_q && bus.p1_req;
            p2_seen_d    = p2_seen_q && bus.p2_req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_CLEAR;
            clr_cnt_q    <= 1'b0;
            settle_cnt_q <= '0;
            turn_q       <= 1'b0;
            move_count_q <= 4'd0;
            winner_q     <= 2'b00;
            game_over_q  <= 1'b0;
            brd_row_q    <= 2'd0;
            brd_col_q    <= 2'd0;
            p1_ack_q     <= 1'b0;
            p1_nak_q     <= 1'b0;
            p2_ack_q     <= 1'b0;
            p2_nak_q     <= 1'b0;
            p1_seen_q    <= 1'b0;
            p2_seen_q    <= 1'b0;
`ifdef TBOX_CTRL_MOVE_TIMEOUT_EN
            to_cnt_q     <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            turn_q       <= turn_d;
            move_count_q <= move_count_d;
            winner_q     <= winner_d;
            game_over_q  <= game_over_d;
            brd_row_q    <= brd_row_d;
            brd_col_q    <= brd_col_d;
            p1_ack_q     <= p1_ack_d;
            p1_nak_q     <= p1_nak_d;
            p2_ack_q     <= p2_ack_d;
            p2_nak_q     <= p2_nak_d;
            p1_seen_q    <= p1_seen_d;
            p2_seen_q    <= p2_seen_d;
`ifdef TBOX_CTRL_MOVE_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign bus.brd_set    = (state_q == S_ISSUE);
    assign bus.brd_reset  = (state_q == S_CLEAR);
    assign bus.busy       = (state_q != S_WAIT_MOVE);
    assign bus.brd_row    = brd_row_q;
    assign bus.brd_col    = brd_col_q;
    assign bus.turn       = turn_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;
    assign bus.move_count = move_count_q;
    assign bus.p1_ack     = p1_ack_q;
    assign bus.p1_nak     = p1_nak_q;
    assign bus.p2_ack     = p2_ack_q;
    assign bus.p2_nak     = p2_nak_q;
endmodule

// File: tb/tb_tbox_game_ctrl.sv
// tb/tb_tbox_game_ctrl.sv - directed self-checking bench for tbox_game_ctrl with a behavioural board
module tb_tbox_game_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   set_cnt = 0;
    int   rst_cnt = 0;

    always #5 clk = ~clk;

    tbox_game_ctrl_if bus ();

    tbox_game_ctrl #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural board: cells register on set, result registers one cycle later.
    logic [8:0] b_valid;
    logic [8:0] b_sym;
    logic       b_next;

    function automatic logic [1:0] board_result(input logic [8:0] v, input logic [8:0] s);
        int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        for (int i = 0; i < 8; i++) begin
            if (v[ln[i][0]] && v[ln[i][1]] && v[ln[i][2]] &&
                s[ln[i][0]] == s[ln[i][1]] && s[ln[i][1]] == s[ln[i][2]])
                return s[ln[i][0]] ? 2'b01 : 2'b10;
        end
        return (v == 9'h1ff) ? 2'b11 : 2'b00;
    endfunction

    always @(posedge clk) begin
        if (bus.brd_reset) begin
            b_valid       <= 9'd0;
            b_sym         <= 9'd0;
            b_next        <= 1'b1;
            bus.brd_state <= 2'b00;
            rst_cnt       <= rst_cnt + 1;
        end else begin
            if (bus.brd_set) begin
                b_valid[(int'(bus.brd_row) - 1) * 3 + int'(bus.brd_col) - 1] <= 1'b1;
                b_sym[(int'(bus.brd_row) - 1) * 3 + int'(bus.brd_col) - 1]   <= b_next;
                b_next  <= ~b_next;
                set_cnt <= set_cnt + 1;
            end
            bus.brd_state <= board_result(b_valid, b_sym);
        end
    end

    assign bus.brd_valid = b_valid;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.busy || bus.game_over) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_idle"}, 16'(ok), 16'd1);
    endtask

    task automatic move(input int p, input logic [1:0] r, input logic [1:0] c,
                        input logic exp_ack, input string tag);
        logic a, n;
        a = 1'b0;
        n = 1'b0;
        @(negedge clk);
        if (p == 1) begin
            bus.p1_req = 1'b1; bus.p1_row = r; bus.p1_col = c;
        end else begin
            bus.p2_req = 1'b1; bus.p2_row = r; bus.p2_col = c;
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            a = (p == 1) ? bus.p1_ack : bus.p2_ack;
            n = (p == 1) ? bus.p1_nak : bus.p2_nak;
            if (a || n) break;
        end
        if (p == 1) bus.p1_req = 1'b0;
        else        bus.p2_req = 1'b0;
        chk({tag, "_ack"}, 16'(a), 16'(exp_ack));
        chk({tag, "_nak"}, 16'(n), 16'(!exp_ack));
        if (a) wait_idle(tag);
    endtask

    task automatic start_new_game(input string tag);
        int r0;
        @(negedge clk);
        r0 = rst_cnt;
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        chk({tag, "_brd_reset"}, 16'(bus.brd_reset), 16'd1);
        chk({tag, "_turn"},      16'(bus.turn), 16'd0);
        chk({tag, "_count"},     16'(bus.move_count), 16'd0);
        chk({tag, "_winner"},    16'(bus.winner), 16'd0);
        chk({tag, "_over"},      16'(bus.game_over), 16'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_rst_cycles"}, 16'(rst_cnt - r0), 16'd2);
        chk({tag, "_busy"},       16'(bus.busy), 16'd0);
    endtask

    logic [1:0] dr [9] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [1:0] dc [9] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd1, 2'd1, 2'd3};

    initial begin
        int s0, r0;
        bus.new_game = 1'b0;
        bus.p1_req = 1'b0; bus.p1_row = 2'd0; bus.p1_col = 2'd0;
        bus.p2_req = 1'b0; bus.p2_row = 2'd0; bus.p2_col = 2'd0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_brd_reset", 16'(bus.brd_reset), 16'd1);
        chk("rst_busy",      16'(bus.busy), 16'd1);
        chk("rst_brd_set",   16'(bus.brd_set), 16'd0);
        chk("rst_outs",      {bus.p1_ack, bus.p1_nak, bus.p2_ack, bus.p2_nak, bus.turn,
                              bus.game_over, bus.winner, bus.move_count, bus.brd_row, bus.brd_col}, 16'd0);
        r0 = rst_cnt;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("rel_rst_cycles", 16'(rst_cnt - r0), 16'd2);
        chk("rel_busy",       16'(bus.busy), 16'd0);

        // Player 1 wins along the top row.
        s0 = set_cnt;
        move(1, 2'd1, 2'd1, 1'b1, "g1_m1");
        chk("g1_turn_after_m1", 16'(bus.turn), 16'd1);
        move(2, 2'd2, 2'd1, 1'b1, "g1_m2");
        move(1, 2'd1, 2'd2, 1'b1, "g1_m3");
        move(2, 2'd2, 2'd2, 1'b1, "g1_m4");
        move(1, 2'd1, 2'd3, 1'b1, "g1_m5");
        chk("g1_winner", 16'(bus.winner), 16'd1);
        chk("g1_over",   16'(bus.game_over), 16'd1);
        chk("g1_count",  16'(bus.move_count), 16'd5);
        chk("g1_sets",   16'(set_cnt - s0), 16'd5);
        chk("g1_rowcol", {12'd0, bus.brd_row, bus.brd_col}, 16'h7);
        move(2, 2'd3, 2'd3, 1'b0, "g1_over_p2");

        // Off-turn, zero coordinate and occupied cell rejections.
        start_new_game("ng2");
        s0 = set_cnt;
        move(2, 2'd1, 2'd1, 1'b0, "offturn_p2");
        chk("offturn_no_set", 16'(set_cnt - s0), 16'd0);
        chk("offturn_turn",   16'(bus.turn), 16'd0);
        move(1, 2'd0, 2'd2, 1'b0, "p1_row0");
        chk("row0_count", 16'(bus.move_count), 16'd0);
        move(1, 2'd1, 2'd1, 1'b1, "p1_11");
        chk("p1_11_turn",  16'(bus.turn), 16'd1);
        move(1, 2'd1, 2'd1, 1'b0, "p1_again");
        move(2, 2'd1, 2'd1, 1'b0, "p2_occupied");
        chk("occ_count", 16'(bus.move_count), 16'd1);
        chk("occ_turn",  16'(bus.turn), 16'd1);

        // Simultaneous requests on player 1's turn.
        start_new_game("ng3");
        @(negedge clk);
        bus.p1_req = 1'b1; bus.p1_row = 2'd2; bus.p1_col = 2'd2;
        bus.p2_req = 1'b1; bus.p2_row = 2'd3; bus.p2_col = 2'd3;
        @(negedge clk);
        chk("sim_resp", {12'd0, bus.p1_ack, bus.p1_nak, bus.p2_ack, bus.p2_nak}, 16'b1001);
        chk("sim_brd_set", 16'(bus.brd_set), 16'd1);
        bus.p1_req = 1'b0;
        bus.p2_req = 1'b0;
        wait_idle("sim");
        chk("sim_turn",   16'(bus.turn), 16'd1);
        chk("sim_rowcol", {12'd0, bus.brd_row, bus.brd_col}, 16'ha);

        // Nine-move draw.
        start_new_game("ng4");
        for (int i = 0; i < 9; i++)
            move((i % 2 == 0) ? 1 : 2, dr[i], dc[i], 1'b1, $sformatf("draw_m%0d", i + 1));
        chk("draw_winner", 16'(bus.winner), 16'd3);
        chk("draw_count",  16'(bus.move_count), 16'd9);
        chk("draw_over",   16'(bus.game_over), 16'd1);
        move(1, 2'd1, 2'd1, 1'b0, "draw_p1_nak");
        move(2, 2'd2, 2'd2, 1'b0, "draw_p2_nak");

        // new_game during the settle of a winning move discards the result.
        start_new_game("ng5");
        move(1, 2'd1, 2'd1, 1'b1, "ab_m1");
        move(2, 2'd2, 2'd1, 1'b1, "ab_m2");
        move(1, 2'd1, 2'd2, 1'b1, "ab_m3");
        move(2, 2'd2, 2'd2, 1'b1, "ab_m4");
        @(negedge clk);
        bus.p1_req = 1'b1; bus.p1_row = 2'd1; bus.p1_col = 2'd3;
        @(negedge clk);
        chk("ab_m5_ack", 16'(bus.p1_ack), 16'd1);
        bus.p1_req = 1'b0;
        @(negedge clk);
        chk("ab_in_settle", {15'd0, bus.busy}, 16'd1);
        r0 = rst_cnt;
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        chk("ab_brd_reset", 16'(bus.brd_reset), 16'd1);
        chk("ab_cleared",   {bus.turn, bus.game_over, bus.winner, bus.move_count}, 16'd0);
        repeat (4) @(negedge clk);
        chk("ab_rst_cycles", 16'(rst_cnt - r0), 16'd2);
        chk("ab_discarded",  {bus.game_over, bus.winner}, 16'd0);
        chk("ab_busy",       16'(bus.busy), 16'd0);
        move(1, 2'd1, 2'd3, 1'b1, "ab_fresh");
        chk("ab_fresh_count", 16'(bus.move_count), 16'd1);

`ifdef TBOX_CTRL_MOVE_TIMEOUT_EN
        // Player 2 idles past the move timer and forfeits.
        start_new_game("ng6");
        move(1, 2'd2, 2'd2, 1'b1, "to_m1");
        begin
            int waited;
            waited = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                waited++;
                if (bus.game_over) break;
            end
            chk("to_over",    16'(bus.game_over), 16'd1);
            chk("to_winner",  16'(bus.winner), 16'd1);
            chk("to_latency", 16'(waited >= 14 && waited <= 18), 16'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
